pulse_bram_reader: RTL and testbench

- Drains the pulse-accumulation BRAM that the pulse generator fills with fp32 pulse-shape sums at LFSR-randomised word offsets.
- Sweeps the BRAM sequentially from word 0 to DEPTH-1 and presents each 32-bit word on a valid/ready sample stream toward the DAC/export path.
- Optionally writes zero back to each word after reading, so the generator can accumulate the next frame from a clean buffer.
- Shares the BRAM port signalling of the generator: byte addressing (word index × 4) and 1-cycle registered read latency.

---
 rtl/pulse_bram_if.sv | 26 ++
 rtl/pulse_bram_reader.sv | 158 +++++++++++++++
 tb/tb_pulse_bram_reader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pulse_bram_if.sv
// rtl/pulse_bram_if.sv - sample stream and BRAM port bundle for pulse_bram_reader
interface pulse_bram_if;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        sample_last;
    logic [31:0] bram_addr;
    logic [31:0] bram_data_in;
    logic        bram_we;
    logic        bram_ena;
    logic [31:0] bram_data_out;

    modport master (
        output sample_data, sample_valid, sample_last,
        input  sample_ready,
        output bram_addr, bram_data_in, bram_we, bram_ena,
        input  bram_data_out
    );

    modport slave (
        input  sample_data, sample_valid, sample_last,
        output sample_ready,
        input  bram_addr, bram_data_in, bram_we, bram_ena,
        output bram_data_out
    );
endinterface

// File: rtl/pulse_bram_reader.sv
// rtl/pulse_bram_reader.sv - sweeps the pulse BRAM and streams each word out
// Optional zero-after-read clearing: define PULSE_BRAM_READER_CLEAR_EN.
module pulse_bram_reader #(
    parameter int DEPTH = 2064,
    parameter int IDX_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cont,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_cnt,
    pulse_bram_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, CAP, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      sample_data_q, sample_data_d;
    logic             sample_valid_q, sample_valid_d;
    logic             sample_last_q, sample_last_d;
    logic [31:0]      bram_addr_q, bram_addr_d;
    logic [31:0]      bram_data_in_q, bram_data_in_d;
    logic             bram_we_q, bram_we_d;
    logic             bram_ena_q, bram_ena_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic [IDX_W-1:0] idx_inc;
    logic             hs;
    logic             at_last_idx;

    assign idx_inc     = idx_q + IDX_W'(1);
    assign hs          = sample_valid_q && bus.sample_ready;
    assign at_last_idx = (idx_q == IDX_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            sample_last_q  <= 1'b0;
            bram_addr_q    <= '0;
            bram_data_in_q <= '0;
            bram_we_q      <= 1'b0;
            bram_ena_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            sample_last_q  <= sample_last_d;
            bram_addr_q    <= bram_addr_d;
            bram_data_in_q <= bram_data_in_d;
            bram_we_q      <= bram_we_d;
            bram_ena_q     <= bram_ena_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WAIT;
            WAIT:    state_d = CAP;
            CAP:     state_d = HOLD;
            HOLD:    if (hs) state_d = (!sample_last_q || cont) ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d          = idx_q;
        sample_data_d  = sample_data_q;
        sample_valid_d = sample_valid_q;
        sample_last_d  = sample_last_q;
        bram_addr_d    = bram_addr_q;
        bram_data_in_d = 32'd0;
        bram_we_d      = bram_we_q;
        bram_ena_d     = bram_ena_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        frame_cnt_d    = frame_cnt_q;
        case (state_q)
            IDLE: begin
                bram_ena_d = 1'b0;
                bram_we_d  = 1'b0;
                if (start) begin
                    idx_d       = '0;
                    bram_addr_d = '0;
                    bram_ena_d  = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            WAIT: begin
                bram_ena_d = 1'b1;
                bram_we_d  = 1'b0;
            end
            CAP: begin
                sample_data_d  = bus.bram_data_out;
                sample_valid_d = 1'b1;
                sample_last_d  = at_last_idx;
`ifdef PULSE_BRAM_READER_CLEAR_EN
                // Zero lands at the address just read, on the edge entering HOLD.
                bram_we_d  = 1'b1;
                bram_ena_d = 1'b1;
`else
                bram_we_d  = 1'b0;
                bram_ena_d = 1'b0;
`endif
            end
            HOLD: begin
                // Port released while stalled so the generator can use the BRAM.
                bram_we_d  = 1'b0;
                bram_ena_d = 1'b0;
                if (hs) begin
                    sample_valid_d = 1'b0;
                    if (!sample_last_q) begin
                        idx_d       = idx_inc;
                        bram_addr_d = 32'(idx_inc) << 2;
                        bram_ena_d  = 1'b1;
                    end else begin
                        sample_last_d = 1'b0;
                        done_d        = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 16'd1;
                        if (cont) begin
                            idx_d       = '0;
                            bram_addr_d = '0;
                            bram_ena_d  = 1'b1;
                        end else begin
                            busy_d = 1'b0;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.sample_data  = sample_data_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.sample_last  = sample_last_q;
    assign bus.bram_addr    = bram_addr_q;
    assign bus.bram_data_in = bram_data_in_q;
    assign bus.bram_we      = bram_we_q;
    assign bus.bram_ena     = bram_ena_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign frame_cnt        = frame_cnt_q;
endmodule

// File: tb/tb_pulse_bram_reader.sv
// tb/tb_pulse_bram_reader.sv - directed table-driven bench for pulse_bram_reader
module tb_pulse_bram_reader;
    localparam int DEPTH = 16;
`ifdef PULSE_BRAM_READER_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cont;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    pulse_bram_if bus();

    pulse_bram_reader #(.DEPTH(DEPTH), .IDX_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    bit          preload_req = 1'b0;
    bit          oob = 1'b0;

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h3F80_0000 + 32'(i);
        end else if (bus.bram_ena) begin
            if (bus.bram_addr >= 32'(DEPTH * 4)) oob <= 1'b1;
            if (bus.bram_we) mem[bus.bram_addr[5:2]] <= bus.bram_data_in;
            bus.bram_data_out <= mem[bus.bram_addr[5:2]];
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic preload();
        preload_req = 1'b1;
        @(posedge clk);
        #1;
        preload_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h3F80_0000 + 32'(i);
    endtask

    function automatic logic [133:0] outs();
        return {bus.sample_data, bus.sample_valid, bus.sample_last, bus.bram_addr,
                bus.bram_data_in, bus.bram_we, bus.bram_ena, busy, done, frame_cnt};
    endfunction

    typedef struct {
        bit          do_rst;
        bit          preload;
        bit          cont;
        int          rdy_mode;
        int          restart_at;
        int          rst_at;
        int          exp_samples;
        int          exp_done;
        logic [15:0] exp_frames;
    } vec_t;

    task automatic run_vec(input vec_t v, input int vn);
        int          cyc, n_samp, n_done, exp_idx, frames_seen, d1, d2;
        bit          seq_ok, stall_ok, stall_prev, rst_pending, timed_out;
        logic [31:0] prev_data;
        logic        prev_last;
        n_samp = 0; n_done = 0; exp_idx = 0; frames_seen = 0; d1 = 0; d2 = 0;
        seq_ok = 1; stall_ok = 1; stall_prev = 0; rst_pending = 0; timed_out = 1;
        prev_data = '0; prev_last = 0;
        if (v.do_rst) do_reset(2);
        if (v.preload) preload();
        cont = v.cont;
        bus.sample_ready = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 1000) begin
            if (done) begin
                n_done++;
                if (n_done == 1) d1 = cyc - 1;
                else d2 = cyc - 1;
            end
            if (stall_prev) begin
                if (bus.sample_valid !== 1'b1 || bus.sample_data !== prev_data ||
                    bus.sample_last !== prev_last || bus.bram_ena !== 1'b0) stall_ok = 0;
            end
            if (rst_pending) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check($sformatf("v%0d_rst_outs", vn), 64'(outs() != '0), 64'd0);
                timed_out = 0;
                break;
            end
            if (!busy) begin
                timed_out = 0;
                break;
            end
            start = 1'b0;
            bus.sample_ready = (v.rdy_mode == 0) ? 1'b1 : (cyc % 4 == 0);
            if (bus.sample_valid && bus.sample_ready) begin
                if (bus.sample_data !== ref_mem[exp_idx] ||
                    bus.sample_last !== (exp_idx == DEPTH - 1) ||
                    bus.bram_addr !== 32'(exp_idx * 4)) seq_ok = 0;
                ref_mem[exp_idx] = CLR ? 32'd0 : ref_mem[exp_idx];
                n_samp++;
                if (frames_seen == 0 && exp_idx == v.restart_at) start = 1'b1;
                if (exp_idx == v.rst_at - 1) rst_pending = 1;
                exp_idx++;
                if (exp_idx == DEPTH) begin
                    exp_idx = 0;
                    frames_seen++;
                end
                if (frames_seen == 1 && exp_idx == 3) cont = 1'b0;
            end
            stall_prev = bus.sample_valid && !bus.sample_ready;
            prev_data  = bus.sample_data;
            prev_last  = bus.sample_last;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        cont  = 1'b0;
        bus.sample_ready = 1'b0;
        check($sformatf("v%0d_timeout", vn), 64'(timed_out), 64'd0);
        check($sformatf("v%0d_samples", vn), 64'(n_samp), 64'(v.exp_samples));
        check($sformatf("v%0d_sequence", vn), 64'(seq_ok), 64'd1);
        check($sformatf("v%0d_done_cnt", vn), 64'(n_done), 64'(v.exp_done));
        check($sformatf("v%0d_frame_cnt", vn), 64'(frame_cnt), 64'(v.exp_frames));
        check($sformatf("v%0d_busy_end", vn), 64'(busy), 64'd0);
        if (v.rdy_mode == 1) check($sformatf("v%0d_stall_stable", vn), 64'(stall_ok), 64'd1);
        if (v.exp_done >= 1 && v.rdy_mode == 0) check($sformatf("v%0d_done_latency", vn), 64'(d1), 64'd48);
        if (v.exp_done == 2) check($sformatf("v%0d_done_gap", vn), 64'(d2 - d1), 64'd48);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1, 1, 0, 0, -1, -1, 16, 1, 16'd1};
        vecs[1] = '{0, 0, 0, 0, -1, -1, 16, 1, 16'd2};
        vecs[2] = '{1, 1, 0, 1, -1, -1, 16, 1, 16'd1};
        vecs[3] = '{1, 1, 0, 0,  5, -1, 16, 1, 16'd1};
        vecs[4] = '{1, 1, 0, 0, -1,  7,  7, 0, 16'd0};
        vecs[5] = '{0, 0, 0, 0, -1, -1, 16, 1, 16'd1};
        vecs[6] = '{1, 1, 1, 0, -1, -1, 32, 2, 16'd2};

        rst = 1'b1; start = 1'b0; cont = 1'b0; bus.sample_ready = 1'b0;
        do_reset(3);
        check("reset_outputs", 64'(outs() != '0), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        preload();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("lat_e1_ena", 64'({bus.bram_ena, bus.bram_we, busy, bus.sample_valid}), 64'b1010);
        check("lat_e1_addr", 64'(bus.bram_addr), 64'd0);
        @(posedge clk); #1;
        check("lat_e2", 64'({bus.bram_ena, bus.sample_valid}), 64'b10);
        @(posedge clk); #1;
        check("lat_e3_valid", 64'(bus.sample_valid), 64'd1);
        check("lat_e3_data", 64'(bus.sample_data), 64'h3F80_0000);
        check("lat_e3_we", 64'({bus.bram_we, bus.bram_ena}), 64'({CLR, CLR}));

        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_beats_start", 64'({busy, bus.bram_ena, bus.sample_valid}), 64'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        check("addr_in_range", 64'(oob), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
